ex_muldiv: RTL

Iterative RV32M multiply/divide unit that sits beside the single-cycle EX ALU and handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It is generalised over operand width XLEN and computes one bit per cycle with a start/busy/done handshake. The pipeline holds EX while busy_o is high and takes result_o, wd_o and wreg_o when done_o pulses. Divide-by-zero and signed overflow take a fast path and complete in one cycle.

---
 rtl/ex_muldiv_if.sv | 32 +++
 rtl/ex_muldiv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// Start/busy/done handshake and operand bundle for the
// iterative RV32M multiply/divide unit.
interface ex_muldiv_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] reg1_i;
   logic [XLEN-1:0] reg2_i;
   logic [4:0]      wd_i;
   logic            wreg_i;
   logic            flush_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic [4:0]      wd_o;
   logic            wreg_o;

   modport master (
      output start_i, op_i, reg1_i, reg2_i,
      output wd_i, wreg_i, flush_i,
      input  busy_o, done_o, result_o,
      input  wd_o, wreg_o
   );

   modport slave (
      input  start_i, op_i, reg1_i, reg2_i,
      input  wd_i, wreg_i, flush_i,
      output busy_o, done_o, result_o,
      output wd_o, wreg_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: one bit per cycle,
// shift-add multiply, restoring divide, one-cycle fast path.
module ex_muldiv #(
   parameter  int XLEN = 32,
   localparam int CNTW = $clog2(XLEN) + 1
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0] MIN_NEG =
      {1'b1, {(XLEN-1){1'b0}}};

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_op;
   logic              r_nega;
   logic              r_negb;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_opd;
   logic [CNTW-1:0]   r_cnt;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_wd_q;
   logic [4:0]        r_wd;
   logic              r_wreg_q;
   logic              r_wreg;

   logic              w_accept;
   logic              w_div;
   logic              w_nega;
   logic              w_negb;
   logic [XLEN-1:0]   w_absa;
   logic [XLEN-1:0]   w_absb;
   logic              w_dz;
   logic              w_ovf;
   logic              w_fast;
   logic [XLEN-1:0]   w_fast_res;
   logic [XLEN:0]     w_msum;
   logic [XLEN:0]     w_shl;
   logic [XLEN:0]     w_diff;
   logic              w_borrow;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_sprod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix_res;

   assign w_accept = bus.start_i & ~bus.flush_i &
                     ((r_state == IDLE) |
                      (r_state == DONE));
   assign w_div    = bus.op_i[2];

   assign w_nega = bus.reg1_i[XLEN-1] &
                   ((bus.op_i == OP_MULH) |
                    (bus.op_i == OP_MULHSU) |
                    (bus.op_i == OP_DIV) |
                    (bus.op_i == OP_REM));
   assign w_negb = bus.reg2_i[XLEN-1] &
                   ((bus.op_i == OP_MULH) |
                    (bus.op_i == OP_DIV) |
                    (bus.op_i == OP_REM));

   assign w_absa = w_nega ? -bus.reg1_i : bus.reg1_i;
   assign w_absb = w_negb ? -bus.reg2_i : bus.reg2_i;

   // Divide-by-zero and MIN/-1 never enter the iterative loop
   assign w_dz   = w_div & (bus.reg2_i == '0);
   assign w_ovf  = ((bus.op_i == OP_DIV) |
                    (bus.op_i == OP_REM)) &
                   (bus.reg1_i == MIN_NEG) &
                   (bus.reg2_i == '1);
   assign w_fast = w_dz | w_ovf;

   always_comb begin
      w_fast_res = '0;
      if (bus.op_i[1]) begin
         w_fast_res = w_dz ? bus.reg1_i : '0;
      end else begin
         w_fast_res = w_dz ? '1 : bus.reg1_i;
      end
   end

   assign w_msum = {1'b0, r_hi} +
                   (r_lo[0] ? {1'b0, r_opd} : '0);

   assign w_shl    = {r_hi, r_lo[XLEN-1]};
   assign w_diff   = w_shl - {1'b0, r_opd};
   assign w_borrow = w_diff[XLEN];

   assign w_prod  = {r_hi, r_lo};
   assign w_sprod = (r_nega ^ r_negb) ? -w_prod : w_prod;
   assign w_quot  = (r_nega ^ r_negb) ? -r_lo : r_lo;
   assign w_rem   = r_nega ? -r_hi : r_hi;

   always_comb begin
      w_fix_res = w_rem;
      unique case (1'b1)
         (r_op == OP_MUL):
            w_fix_res = w_sprod[XLEN-1:0];
         (!r_op[2] && r_op != OP_MUL):
            w_fix_res = w_sprod[2*XLEN-1:XLEN];
         (r_op[2] && !r_op[1]):
            w_fix_res = w_quot;
         (r_op[2] && r_op[1]):
            w_fix_res = w_rem;
         default:
            w_fix_res = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, DONE: begin
            if (w_accept) begin
               w_next = w_fast ? DONE : CALC;
            end else begin
               w_next = IDLE;
            end
         end
         CALC: begin
            if (r_cnt == CNTW'(1)) begin
               w_next = FIX;
            end
         end
         FIX:     w_next = DONE;
         default: w_next = IDLE;
      endcase
      if (bus.flush_i) begin
         w_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op     <= '0;
         r_nega   <= 1'b0;
         r_negb   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opd    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_wd_q   <= '0;
         r_wd     <= '0;
         r_wreg_q <= 1'b0;
         r_wreg   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op     <= bus.op_i;
            r_nega   <= w_nega;
            r_negb   <= w_negb;
            r_wd_q   <= bus.wd_i;
            r_wreg_q <= bus.wreg_i;
            r_cnt    <= CNTW'(XLEN);
            r_hi     <= '0;
            // lo holds the bits consumed per cycle
            r_lo     <= w_div ? w_absa : w_absb;
            r_opd    <= w_div ? w_absb : w_absa;
            if (w_fast) begin
               r_result <= w_fast_res;
               r_wd     <= bus.wd_i;
               r_wreg   <= bus.wreg_i;
            end
         end else if (r_state == CALC) begin
            if (r_op[2]) begin
               r_hi <= w_borrow ? w_shl[XLEN-1:0]
                                : w_diff[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], ~w_borrow};
            end else begin
               r_hi <= w_msum[XLEN:1];
               r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= r_cnt - CNTW'(1);
         end else if (r_state == FIX && !bus.flush_i) begin
            r_result <= w_fix_res;
            r_wd     <= r_wd_q;
            r_wreg   <= r_wreg_q;
         end
         if (bus.flush_i && r_state != IDLE) begin
            r_wreg <= 1'b0;
         end
      end
   end

   assign bus.busy_o   = (r_state == CALC) |
                         (r_state == FIX);
   assign bus.done_o   = (r_state == DONE) & ~bus.flush_i;
   assign bus.result_o = r_result;
   assign bus.wd_o     = r_wd;
   assign bus.wreg_o   = r_wreg;
endmodule
